// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned Q_DEPTH = 2;
  localparam int unsigned PC_INC  = 2;

  localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_e;

  // One queued instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request/response bus; at most one request outstanding.
interface fetch_unit_if;
  import fetch_pkg::*;

  logic               req;
  logic [ADDR_W-1:0]  addr;
  logic               ready;
  logic               rvalid;
  logic [INSTR_W-1:0] rdata;

  modport master (
    output req,
    output addr,
    input  ready,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output ready,
    output rvalid,
    output rdata
  );

endinterface

// File: rtl/fetch_queue.sv
// Small power-of-two FIFO of fetched instructions with a synchronous flush.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = Q_DEPTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_data,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  fetch_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic                     do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  // Pointer/occupancy update; flush wins over any same-cycle push or pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: drives the PC register, fetches from imem, queues for decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = Q_DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc_cur,
  output logic               pc_write,
  output logic [ADDR_W-1:0]  pc_next,
  fetch_unit_if.master       imem,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  input  logic               id_ready
);

  fetch_state_e      state_q, state_d;
  logic              kill_q, kill_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              redir;
  logic              q_push, q_flush, q_full, q_empty;
  fetch_entry_t      q_head, q_wdata;

  // Redirects are ignored while reset is held so every output sits at its reset value.
  assign redir   = redirect_valid && !reset;
  assign q_wdata = '{instr: imem.rdata, pc: req_pc_q};

  assign if_valid = !q_empty;
  assign if_instr = q_head.instr;
  assign if_pc    = q_head.pc;

  fetch_queue #(
    .DEPTH(QUEUE_DEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (q_push),
    .pop       (id_ready),
    .flush     (q_flush),
    .push_data (q_wdata),
    .head      (q_head),
    .full      (q_full),
    .empty     (q_empty)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: one idle cycle, then alternate request / wait-for-response.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = REQ;
      REQ:     if (imem.req && imem.ready) state_d = WAIT;
      WAIT:    if (imem.rvalid) state_d = REQ;
      default: state_d = IDLE;
    endcase
  end

  // Outputs and datapath updates; a redirect overrides the sequential PC step.
  always_comb begin
    imem.req  = 1'b0;
    imem.addr = RESET_PC;
    pc_write  = 1'b0;
    pc_next   = RESET_PC;
    kill_d    = kill_q;
    req_pc_d  = req_pc_q;
    q_push    = 1'b0;
    q_flush   = 1'b0;
    case (state_q)
      REQ: begin
        // Only request when a slot is guaranteed for the response.
        if (!q_full && !redir) begin
          imem.req  = 1'b1;
          imem.addr = pc_cur;
          if (imem.ready) begin
            pc_write = 1'b1;
            pc_next  = pc_cur + ADDR_W'(PC_INC);
            req_pc_d = pc_cur;
          end
        end
      end
      WAIT: begin
        if (imem.rvalid) begin
          q_push = !kill_q;
          kill_d = 1'b0;
        end
      end
      default: ;
    endcase
    if (redir) begin
      pc_write = 1'b1;
      pc_next  = redirect_pc;
      q_flush  = 1'b1;
      // A response arriving in this same cycle is already dropped by the flush.
      if (state_q == WAIT && !imem.rvalid) begin
        kill_d = 1'b1;
      end
    end
  end

  // Kill flag and outstanding request PC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kill_q   <= 1'b0;
      req_pc_q <= RESET_PC;
    end else begin
      kill_q   <= kill_d;
      req_pc_q <= req_pc_d;
    end
  end

endmodule
